fpu_cmd_sequencer: RTL and testbench
====================================

// Module: fpu_cmd_sequencer
// PURPOSE
//  Command-side initiator for the FPU control FSM. Accepts one operation per
//  valid/ready handshake as {a, b, op}, with a and b in FP16 format. Unpacks a and b to the
//  18-bit working format. Steps the FPU FSM through its load states with
//  single-cycle start pulses. Captures result/error and returns it on a
//  valid/ready response port. Sits between the host/UART front end and the FPU FSM.
// PARAMETERS
//  TIMEOUT   64   max cycles waited in any FPU wait state before abort (>=4)
//  CNT_W     7    width of timeout counter, must hold TIMEOUT
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   sequencer can accept a command
//  cmd_a        in   16  operand A, FP16 {s,e[4:0],m[9:0]}
//  cmd_b        in   16  operand B, FP16
//  cmd_op       in   2   0 add, 1 sub, 2 mul, 3 div
//  fpu_start    out  1   step pulse to FPU FSM
//  fpu_a        out  18  working A {s,e[4:0],1'b0,hid,m[9:0]}
//  fpu_b        out  18  working B, same format
//  fpu_o        out  18  {16'b0, op}
//  fpu_ena_a    in   1   FPU in A-load state
//  fpu_ena_b    in   1   FPU in B-load state
//  fpu_ena_o    in   1   FPU in op-load state
//  fpu_ready    in   1   FPU result valid (one cycle)
//  fpu_error    in   1   FPU error (one cycle)
//  fpu_result   in   16  FPU result, FP16
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer takes response
//  rsp_data     out  16  captured result; 16'h0 on error/timeout
//  rsp_status   out  2   0 ok, 1 fpu error, 2 timeout
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=0 during reset, 1 in first IDLE cycle; state IDLE.
//  Unpack: hid = (e != 0); m passed unchanged; bit 11 always 0.
//  States and transitions:
//   IDLE  : cmd_ready=1; on cmd_valid latch a/b/op into fpu_a/b/o -> KICK_A.
//   KICK_A: fpu_start=1 for one cycle -> WAIT_A.
//   WAIT_A: fpu_ena_a -> KICK_B.
//   KICK_B: fpu_start=1 for one cycle -> WAIT_B.
//   WAIT_B: fpu_ena_b -> KICK_O.
//   KICK_O: fpu_start=1 for one cycle -> WAIT_O.
//   WAIT_O: fpu_ena_o -> KICK_X.
//   KICK_X: fpu_start=1 for one cycle -> WAIT_R.
//   WAIT_R: on fpu_error, capture status=1 and data=0 -> RSP; else on fpu_ready,
//           capture status=0 and data=fpu_result -> RSP.
//   RSP   : rsp_valid=1; outputs stable until rsp_ready -> IDLE.
//  fpu_start is 0 in every non-KICK state. Never two consecutive start cycles.
//  fpu_a/b/o are registered at accept and held until the return to IDLE.
//  Timeout: counter clears on entry to each WAIT_*. At TIMEOUT cycles in the same
//   WAIT_*, capture status=2 and data=0 -> RSP. A timeout in WAIT_A..WAIT_O leaves
//   the FPU mid-sequence; recovery is by external reset.
//  Simultaneous fpu_error and fpu_ready: error wins.
//  Events in WAIT_R arriving in the same cycle as entry are sampled. Ready/error
//   seen outside WAIT_R are ignored.
//  cmd_valid is ignored outside IDLE. cmd_ready=0 outside IDLE.
//  Accept-to-first-start latency is 1 cycle. Back-to-back commands: IDLE is
//   entered for at least one cycle between responses.
//  Reset mid-operation: immediate return to IDLE with all outputs cleared. No
//   response is issued for the aborted command.
// STRUCTURE
//  fpu_pkg: op codes, FP16/working widths, rsp_status codes, state encoding.
//  Sub-module fp16_unpack (combinational FP16 -> 18-bit working format), two instances.
//  Top-level: FSM, timeout counter, operand/response registers.
// TESTING
//  1. a=16'h3C00, b=16'h4000, op=0; FPU model returns 16'h4200 -> 4 start pulses,
//     fpu_a=18'h0F400, fpu_b=18'h10400, rsp 16'h4200 with status 0.
//  2. a exponent 0 (16'h0001): fpu_a hidden bit = 0, i.e. fpu_a=18'h00001.
//  3. FPU model never asserts fpu_ena_b -> rsp_status=2 exactly TIMEOUT cycles
//     after entry to WAIT_B; rsp_data=0.
//  4. fpu_ready and fpu_error in the same cycle -> rsp_status=1, rsp_data=0.
//  5. rsp_ready held low for 10 cycles -> rsp_valid/data stable; new cmd_valid is
//     not accepted until after the handshake.
//  6. rst low while in WAIT_O -> all outputs 0 that cycle. After release,
//     cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the FPU command path.
// Op codes, word widths, response codes, sequencer states.
package fpu_pkg;

   localparam int FP_W = 16;
   localparam int WK_W = 18;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK  = 2'd0,
      ST_ERR = 2'd1,
      ST_TMO = 2'd2
   } rsp_st_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_KICK_A,
      S_WAIT_A,
      S_KICK_B,
      S_WAIT_B,
      S_KICK_O,
      S_WAIT_O,
      S_KICK_X,
      S_WAIT_R,
      S_RSP
   } state_e;

endpackage

// File: rtl/fp16_unpack.sv
// FP16 to 18-bit working format.
// {s,e,1'b0,hid,m}; hidden bit set for any nonzero exponent.
module fp16_unpack
   import fpu_pkg::*;
(
   input  logic [FP_W-1:0] fp,
   output logic [WK_W-1:0] wk
);

   logic hid;

   assign hid = |fp[14:10];
   assign wk  = {fp[15], fp[14:10], 1'b0, hid, fp[9:0]};

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Command-side initiator for the FPU control FSM.
// Walks the FPU through its load states, returns result/status.
module fpu_cmd_sequencer
   import fpu_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [FP_W-1:0] cmd_a,
   input  logic [FP_W-1:0] cmd_b,
   input  logic [1:0]      cmd_op,
   output logic            fpu_start,
   output logic [WK_W-1:0] fpu_a,
   output logic [WK_W-1:0] fpu_b,
   output logic [WK_W-1:0] fpu_o,
   input  logic            fpu_ena_a,
   input  logic            fpu_ena_b,
   input  logic            fpu_ena_o,
   input  logic            fpu_ready,
   input  logic            fpu_error,
   input  logic [FP_W-1:0] fpu_result,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [FP_W-1:0] rsp_data,
   output logic [1:0]      rsp_status
);

   state_e            state;
   state_e            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [WK_W-1:0]   a_wk;
   logic [WK_W-1:0]   b_wk;
   logic              tmo;
   logic              cap;
   logic [1:0]        cap_st;
   logic [FP_W-1:0]   cap_data;

   fp16_unpack u_unp_a (.fp(cmd_a), .wk(a_wk));
   fp16_unpack u_unp_b (.fp(cmd_b), .wk(b_wk));

   // last permitted cycle in the current wait state
   assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // next state, strobes and response capture select
   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      fpu_start = 1'b0;
      rsp_valid = 1'b0;
      cap       = 1'b0;
      cap_st    = ST_OK;
      cap_data  = '0;
      unique case (state)
         S_IDLE: begin
            cmd_ready = rst;
            if (cmd_valid) state_nx = S_KICK_A;
         end
         S_KICK_A: begin
            fpu_start = 1'b1;
            state_nx  = S_WAIT_A;
         end
         S_WAIT_A: begin
            if (fpu_ena_a) state_nx = S_KICK_B;
            else if (tmo) begin
               state_nx = S_RSP;
               cap      = 1'b1;
               cap_st   = ST_TMO;
            end
         end
         S_KICK_B: begin
            fpu_start = 1'b1;
            state_nx  = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (fpu_ena_b) state_nx = S_KICK_O;
            else if (tmo) begin
               state_nx = S_RSP;
               cap      = 1'b1;
               cap_st   = ST_TMO;
            end
         end
         S_KICK_O: begin
            fpu_start = 1'b1;
            state_nx  = S_WAIT_O;
         end
         S_WAIT_O: begin
            if (fpu_ena_o) state_nx = S_KICK_X;
            else if (tmo) begin
               state_nx = S_RSP;
               cap      = 1'b1;
               cap_st   = ST_TMO;
            end
         end
         S_KICK_X: begin
            fpu_start = 1'b1;
            state_nx  = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (fpu_error) begin
               state_nx = S_RSP;
               cap      = 1'b1;
               cap_st   = ST_ERR;
            end else if (fpu_ready) begin
               state_nx = S_RSP;
               cap      = 1'b1;
               cap_st   = ST_OK;
               cap_data = fpu_result;
            end else if (tmo) begin
               state_nx = S_RSP;
               cap      = 1'b1;
               cap_st   = ST_TMO;
            end
         end
         S_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // operand latch at accept, wait counter, response capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpu_a      <= '0;
         fpu_b      <= '0;
         fpu_o      <= '0;
         cnt        <= '0;
         rsp_data   <= '0;
         rsp_status <= '0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            fpu_a <= a_wk;
            fpu_b <= b_wk;
            fpu_o <= {{(WK_W-2){1'b0}}, cmd_op};
         end
         if (fpu_start) cnt <= '0;
         else           cnt <= cnt + 1'b1;
         if (cap) begin
            rsp_data   <= cap_data;
            rsp_status <= cap_st;
         end
      end
   end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Bench for fpu_cmd_sequencer: vector table, random ops, reset abort.
// The FPU side is modelled as per-phase reply delays.
module tb_fpu_cmd_sequencer;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [1:0]  cmd_op;
   logic        fpu_start;
   logic [17:0] fpu_a;
   logic [17:0] fpu_b;
   logic [17:0] fpu_o;
   logic        fpu_ena_a;
   logic        fpu_ena_b;
   logic        fpu_ena_o;
   logic        fpu_ready;
   logic        fpu_error;
   logic [15:0] fpu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_status;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      int          dly [4];
      int          mode;
      logic [15:0] res;
      int          hold;
      bit          noise;
      logic [17:0] fa;
      logic [17:0] fb;
      logic [15:0] data;
      logic [1:0]  st;
      int          starts;
   } txn_t;

   txn_t tbl [7];

   fpu_cmd_sequencer #(.TIMEOUT(TO), .CNT_W(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .fpu_start  (fpu_start),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_o      (fpu_o),
      .fpu_ena_a  (fpu_ena_a),
      .fpu_ena_b  (fpu_ena_b),
      .fpu_ena_o  (fpu_ena_o),
      .fpu_ready  (fpu_ready),
      .fpu_error  (fpu_error),
      .fpu_result (fpu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_status (rsp_status)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [17:0] unpk(input logic [15:0] f);
      int s;
      int e;
      int m;
      s = int'(f >> 15);
      e = int'((f >> 10) & 16'd31);
      m = int'(f & 16'd1023);
      return 18'(s * (1 << 17) + e * (1 << 12)
                 + (e != 0 ? 1 : 0) * (1 << 10) + m);
   endfunction

   function automatic void model(inout txn_t t);
      t.fa = unpk(t.a);
      t.fb = unpk(t.b);
      for (int ph = 0; ph < 4; ph++) begin
         if (t.dly[ph] >= TO) begin
            t.st     = 2'd2;
            t.data   = 16'h0;
            t.starts = ph + 1;
            return;
         end
      end
      t.starts = 4;
      t.st     = (t.mode == 0) ? 2'd0 : 2'd1;
      t.data   = (t.mode == 0) ? t.res : 16'h0;
   endfunction

   function automatic txn_t mk(
      input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
      input int d0, input int d1, input int d2, input int d3,
      input int mode, input logic [15:0] res, input int hold,
      input logic [17:0] fa, input logic [17:0] fb,
      input logic [15:0] data, input logic [1:0] st, input int starts);
      txn_t t;
      t.a = a; t.b = b; t.op = op;
      t.dly[0] = d0; t.dly[1] = d1; t.dly[2] = d2; t.dly[3] = d3;
      t.mode = mode; t.res = res; t.hold = hold; t.noise = 1'b0;
      t.fa = fa; t.fb = fb; t.data = data; t.st = st;
      t.starts = starts;
      return t;
   endfunction

   task automatic do_txn(input txn_t t, input string tag);
      int          starts;
      int          to_wc;
      int          wc;
      int          guard;
      bit          tmo_seen;
      bit          glitch;
      bit          done;
      bit          unstable;
      logic [15:0] d0;
      logic [1:0]  s0;
      starts   = 0;
      to_wc    = 0;
      tmo_seen = 1'b0;
      glitch   = 1'b0;
      unstable = 1'b0;
      cmd_a     = t.a;
      cmd_b     = t.b;
      cmd_op    = t.op;
      cmd_valid = 1'b1;
      guard     = 0;
      while (!cmd_ready && guard < 200) begin
         step();
         guard++;
      end
      chk({tag, " accept"}, 32'(guard < 200), 32'd1);
      step();
      cmd_valid = 1'b0;
      chk({tag, " fpu_a"}, 32'(fpu_a), 32'(t.fa));
      chk({tag, " fpu_b"}, 32'(fpu_b), 32'(t.fb));
      chk({tag, " fpu_o"}, 32'(fpu_o), 32'(t.op));
      for (int ph = 0; ph < 4 && !tmo_seen; ph++) begin
         if (fpu_start) starts++;
         step();
         wc   = 0;
         done = 1'b0;
         while (!done) begin
            if (rsp_valid || wc > TO + 4) begin
               tmo_seen = 1'b1;
               to_wc    = wc;
               done     = 1'b1;
            end else begin
               if (fpu_start) glitch = 1'b1;
               if (wc == t.dly[ph]) begin
                  case (ph)
                     0: fpu_ena_a = 1'b1;
                     1: fpu_ena_b = 1'b1;
                     2: fpu_ena_o = 1'b1;
                     default: begin
                        fpu_result = t.res;
                        fpu_ready  = (t.mode != 1);
                        fpu_error  = (t.mode != 0);
                     end
                  endcase
                  step();
                  fpu_ena_a  = 1'b0;
                  fpu_ena_b  = 1'b0;
                  fpu_ena_o  = 1'b0;
                  fpu_ready  = 1'b0;
                  fpu_error  = 1'b0;
                  fpu_result = 16'hDEAD;
                  done       = 1'b1;
               end else begin
                  if (ph < 3 && t.noise) begin
                     fpu_ready = 1'($urandom_range(0, 1));
                     fpu_error = 1'($urandom_range(0, 1));
                  end
                  step();
                  fpu_ready = 1'b0;
                  fpu_error = 1'b0;
                  wc++;
               end
            end
         end
      end
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      d0        = rsp_data;
      s0        = rsp_status;
      cmd_a     = ~t.a;
      cmd_valid = 1'b1;
      for (int h = 0; h < t.hold; h++) begin
         if (!rsp_valid || rsp_data !== d0 || rsp_status !== s0
             || cmd_ready || fpu_start || fpu_a !== t.fa)
            unstable = 1'b1;
         step();
      end
      chk({tag, " stable"}, 32'(unstable), 32'd0);
      chk({tag, " data"}, 32'(rsp_data), 32'(t.data));
      chk({tag, " status"}, 32'(rsp_status), 32'(t.st));
      chk({tag, " starts"}, 32'(starts), 32'(t.starts));
      chk({tag, " start_gap"}, 32'(glitch), 32'd0);
      if (t.st == 2'd2)
         chk({tag, " tmo_lat"}, 32'(to_wc), 32'(TO));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
      chk({tag, " idle"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t;
      bit   bad;
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_a      = '0;
      cmd_b      = '0;
      cmd_op     = '0;
      fpu_ena_a  = 1'b0;
      fpu_ena_b  = 1'b0;
      fpu_ena_o  = 1'b0;
      fpu_ready  = 1'b0;
      fpu_error  = 1'b0;
      fpu_result = '0;
      rsp_ready  = 1'b0;

      tbl[0] = mk(16'h3C00, 16'h4000, 2'd0, 1, 1, 1, 2, 0, 16'h4200, 0,
                  18'h0F400, 18'h10400, 16'h4200, 2'd0, 4);
      tbl[1] = mk(16'h0001, 16'h8400, 2'd2, 0, 0, 0, 0, 0, 16'h1234, 0,
                  18'h00001, 18'h21400, 16'h1234, 2'd0, 4);
      tbl[2] = mk(16'h3C00, 16'h4000, 2'd1, 2, 1000, 0, 0, 0, 16'h0, 1,
                  18'h0F400, 18'h10400, 16'h0000, 2'd2, 2);
      tbl[3] = mk(16'h4500, 16'hC000, 2'd3, 3, 0, 5, 1, 2, 16'h7777, 2,
                  18'h11500, 18'h30400, 16'h0000, 2'd1, 4);
      tbl[4] = mk(16'h7BFF, 16'h0400, 2'd3, 0, 2, 0, 3, 0, 16'h5555, 10,
                  18'h1E7FF, 18'h01400, 16'h5555, 2'd0, 4);
      tbl[5] = mk(16'h0000, 16'h83FF, 2'd0, 0, 0, 0, TO - 1, 1, 16'hABCD, 1,
                  18'h00000, 18'h203FF, 16'h0000, 2'd1, 4);
      tbl[6] = mk(16'h3555, 16'hFC00, 2'd2, 0, 0, 0, TO, 0, 16'h9999, 0,
                  18'h0D555, 18'h3F400, 16'h0000, 2'd2, 4);

      repeat (3) step();
      chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst start", 32'(fpu_start), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst fpu_a", 32'(fpu_a), 32'd0);
      chk("rst rsp", 32'({rsp_data, rsp_status}), 32'd0);
      rst = 1'b1;
      #1;
      chk("first idle ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 7; i++)
         do_txn(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 24; i++) begin
         t.a  = 16'($urandom);
         t.b  = 16'($urandom);
         t.op = 2'($urandom_range(0, 3));
         for (int ph = 0; ph < 4; ph++)
            t.dly[ph] = ($urandom_range(0, 11) == 0)
                        ? TO + int'($urandom_range(0, 2))
                        : int'($urandom_range(0, 4));
         t.mode  = int'($urandom_range(0, 2));
         t.res   = 16'($urandom);
         t.hold  = int'($urandom_range(0, 3));
         t.noise = 1'b1;
         model(t);
         do_txn(t, $sformatf("rnd%0d", i));
      end

      chk("pre-abort ready", 32'(cmd_ready), 32'd1);
      cmd_a     = 16'h3C00;
      cmd_b     = 16'h4000;
      cmd_op    = 2'd2;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      fpu_ena_a = 1'b1;
      step();
      fpu_ena_a = 1'b0;
      step();
      fpu_ena_b = 1'b1;
      step();
      fpu_ena_b = 1'b0;
      step();
      chk("abort pre fpu_o", 32'(fpu_o), 32'd2);
      chk("abort pre busy", 32'({cmd_ready, fpu_start, rsp_valid}), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort ctl", 32'({cmd_ready, fpu_start, rsp_valid}), 32'd0);
      chk("abort fpu_a", 32'(fpu_a), 32'd0);
      chk("abort fpu_b", 32'(fpu_b), 32'd0);
      chk("abort fpu_o", 32'(fpu_o), 32'd0);
      chk("abort rsp", 32'({rsp_data, rsp_status}), 32'd0);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("abort release ready", 32'(cmd_ready), 32'd1);
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (rsp_valid || fpu_start) bad = 1'b1;
         step();
      end
      chk("abort no rsp", 32'(bad), 32'd0);
      do_txn(tbl[0], "post_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
